// File: rtl/alu_sweep_checker.sv
// alu_sweep_checker: built-in self-test that sweeps every ALU vector and counts mismatches/timeouts
module alu_sweep_checker #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             alu_reset,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_opcode,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out_high,
  input  logic [WIDTH-1:0] alu_out_low,
  input  logic             alu_flag,
  input  logic             alu_done,
  output logic             busy,
  output logic             finished,
  output logic [15:0]      err_count,
  output logic             timeout_seen,
  output logic [WIDTH-1:0] first_err_op,
  output logic [WIDTH-1:0] first_err_in1,
  output logic [WIDTH-1:0] first_err_in2
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, RST, GAP1, GAP2, START, WAIT, CHECK, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d, in1_q, in1_d, in2_q, in2_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] fop_q, fop_d, fin1_q, fin1_d, fin2_q, fin2_d;
  logic             flag_q, flag_d, tmo_q, tmo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      err_q, err_d;
  logic [WIDTH:0]   sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  logic             ok, err_now, last;
  always_comb begin
    sum  = {1'b0, in1_q} + {1'b0, in2_q};
    diff = {1'b0, in1_q} - {1'b0, in2_q};
    prod = {{WIDTH{1'b0}}, in1_q} * {{WIDTH{1'b0}}, in2_q};
    quo  = (in2_q == '0) ? '0 : in1_q / in2_q;
    rem  = (in2_q == '0) ? '0 : in1_q % in2_q;
    ok   = (op_q == WIDTH'(0)) ? (lo_q == sum[WIDTH-1:0] && flag_q == sum[WIDTH]) :
           (op_q == WIDTH'(1)) ? (lo_q == diff[WIDTH-1:0] && flag_q == diff[WIDTH]) :
           (op_q == WIDTH'(2)) ? ({hi_q, lo_q} == prod) :
           (in2_q == '0)       ? flag_q :
                                 (hi_q == quo && lo_q == rem && !flag_q);
    last = (&in2_q) && (&in1_q) && (op_q == WIDTH'(NUM_OPS - 1));
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    fop_d   = fop_q;
    fin1_d  = fin1_q;
    fin2_d  = fin2_q;
    err_now = 1'b0;
    case (state_q)
      IDLE, FIN: if (go) begin
        state_d = RST;
        op_d    = '0;
        in1_d   = '0;
        in2_d   = '0;
        err_d   = '0;
        tmo_d   = 1'b0;
        fop_d   = '0;
        fin1_d  = '0;
        fin2_d  = '0;
      end
      RST:   state_d = GAP1;
      GAP1:  state_d = GAP2;
      GAP2:  state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (alu_done) begin
        state_d = CHECK;
        hi_d    = alu_out_high;
        lo_d    = alu_out_low;
        flag_d  = alu_flag;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = NEXT;
        tmo_d   = 1'b1;
        err_now = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      CHECK: begin
        state_d = NEXT;
        err_now = !ok;
      end
      NEXT: begin
        state_d = last ? FIN : RST;
        in2_d   = last ? in2_q : in2_q + WIDTH'(1);
        in1_d   = (!last && (&in2_q)) ? in1_q + WIDTH'(1) : in1_q;
        op_d    = (!last && (&in2_q) && (&in1_q)) ? op_q + WIDTH'(1) : op_q;
      end
      default: state_d = IDLE;
    endcase
    // the first error is the one that finds the counter still at zero
    if (err_now) begin
      err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      fop_d  = (err_q == '0) ? op_q : fop_q;
      fin1_d = (err_q == '0) ? in1_q : fin1_q;
      fin2_d = (err_q == '0) ? in2_q : fin2_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
      fop_q   <= '0;
      fin1_q  <= '0;
      fin2_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      fop_q   <= fop_d;
      fin1_q  <= fin1_d;
      fin2_q  <= fin2_d;
    end
  end
  assign alu_reset     = reset | (state_q == RST);
  assign alu_start     = (state_q == START);
  assign alu_opcode    = op_q;
  assign alu_in1       = in1_q;
  assign alu_in2       = in2_q;
  assign busy          = (state_q != IDLE) && (state_q != FIN);
  assign finished      = (state_q == FIN);
  assign err_count     = err_q;
  assign timeout_seen  = tmo_q;
  assign first_err_op  = fop_q;
  assign first_err_in1 = fin1_q;
  assign first_err_in2 = fin2_q;
endmodule
